// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state encoding and router command constants
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic [7:0] CMD_BANG   = 8'h21;
  localparam logic [7:0] CMD_AT     = 8'h40;
  localparam logic [7:0] CMD_HASH   = 8'h23;
  localparam logic [7:0] CMD_DOLLAR = 8'h24;

  function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
    return clk_hz / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// rtl/uart_rx_byte_if.sv - serial line in, received byte and status strobes out
interface uart_rx_byte_if;
  logic       rx;
  logic [7:0] data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  modport slave (
    input  rx,
    output data, rx_done, frame_err, busy
  );

  modport master (
    output rx,
    input  data, rx_done, frame_err, busy
  );
endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, held at zero while clr is high
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int OVS    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVS);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver, 16x oversampling, mid-bit sampling
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int OVS    = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_byte_if.slave  rxi
);

  uart_state_e state_q, state_d;
  logic       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0] os_q, os_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       ferr_q, ferr_d;
  logic       wait_high_q, wait_high_d;
  logic       rx_s;
  logic       tick;

  uart_baud_tick #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .OVS    (OVS)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == IDLE),
    .tick (tick)
  );

  assign rx_s = sync2_q;

  always_comb begin
    state_d     = state_q;
    sync1_d     = rxi.rx;
    sync2_d     = sync1_q;
    os_d        = os_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    wait_high_d = wait_high_q;
    done_d      = 1'b0;
    ferr_d      = 1'b0;
    case (state_q)
      IDLE: begin
        // After a framing error the line must be seen high before a new start is accepted.
        if (wait_high_q) begin
          if (rx_s) wait_high_d = 1'b0;
        end else if (!rx_s) begin
          state_d = START;
          os_d    = 4'd0;
        end
      end
      START: begin
        if (tick) begin
          if (os_q == 4'd7) begin
            os_d = 4'd0;
            if (!rx_s) begin
              state_d = DATA;
              bit_d   = 3'd0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            os_d = os_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          os_d = os_q + 4'd1;
          if (os_q == 4'd15) begin
            shift_d = {rx_s, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          os_d = os_q + 4'd1;
          if (os_q == 4'd15) begin
            state_d = IDLE;
            if (rx_s) begin
              data_d = shift_q;
              done_d = 1'b1;
            end else begin
              ferr_d      = 1'b1;
              wait_high_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      os_q        <= 4'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
      wait_high_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      os_q        <= os_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      done_q      <= done_d;
      ferr_q      <= ferr_d;
      wait_high_q <= wait_high_d;
    end
  end

  assign rxi.data      = data_q;
  assign rxi.rx_done   = done_q;
  assign rxi.frame_err = ferr_q;
  assign rxi.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - scoreboard bench for uart_rx_byte at 50 MHz / 115200 baud
module tb_uart_rx_byte;

  localparam int BIT_CLKS = 434;
  localparam int DIV      = 27;
  localparam int LAT_NOM  = 2 + (8 + 16 * 9) * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_byte_if ifc ();

  uart_rx_byte #(
    .CLK_HZ (50_000_000),
    .BAUD   (115200),
    .OVS    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rxi (ifc)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int unstable_cnt = 0;
  int last_done_cyc = 0;
  int start_cyc = 0;
  int rd_idx = 0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] last_good = 8'h00;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.rx_done) begin
        got_q.push_back(ifc.data);
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (ifc.frame_err) ferr_cnt++;
      if (ifc.rx_done && ifc.frame_err) both_cnt++;
      if (ifc.data !== prev_data && !ifc.rx_done) unstable_cnt++;
    end
    prev_data = ifc.data;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int bit_clks, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ifc.rx = bits[i];
      if (i == 0) start_cyc = cyc;
      idle(bit_clks);
    end
    ifc.rx = 1'b1;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(posedge clk);
    #1;
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL wait_done timeout: rx_done count %0d, required %0d", done_cnt, target);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (ifc.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", ifc.data); end
    checks++;
    if (ifc.rx_done !== 1'b0) begin errors++; $display("FAIL reset_rx_done: got %b want 0", ifc.rx_done); end
    checks++;
    if (ifc.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", ifc.frame_err); end
    checks++;
    if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", ifc.busy); end
    idle(1);
  endtask

  task automatic test_single;
    int d0, f0, lat;
    logic [7:0] e;
    d0 = done_cnt;
    f0 = ferr_cnt;
    exp_q.push_back(uart_pkg::CMD_BANG);
    send_frame(8'h21, BIT_CLKS, 1'b1);
    wait_done(d0 + 1, 200);
    while (rd_idx < got_q.size() && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q[rd_idx] !== e) begin errors++; $display("FAIL single_data: got %h want %h", got_q[rd_idx], e); end
      rd_idx++;
      last_good = e;
    end
    lat = last_done_cyc - start_cyc;
    checks++;
    if (lat < LAT_NOM - 1 || lat > LAT_NOM + 2) begin
      errors++;
      $display("FAIL single_latency: got %0d clocks want %0d..%0d", lat, LAT_NOM - 1, LAT_NOM + 2);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", done_cnt - d0); end
    checks++;
    if (ferr_cnt !== f0) begin errors++; $display("FAIL single_frame_err: got %0d want %0d", ferr_cnt, f0); end
  endtask

  task automatic test_back_to_back;
    int d0;
    logic [7:0] e;
    d0 = done_cnt;
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h23);
    send_frame(8'h40, BIT_CLKS, 1'b1);
    send_frame(8'h23, BIT_CLKS, 1'b1);
    wait_done(d0 + 2, 200);
    while (rd_idx < got_q.size() && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q[rd_idx] !== e) begin errors++; $display("FAIL b2b_data: got %h want %h", got_q[rd_idx], e); end
      rd_idx++;
      last_good = e;
    end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_missing: %0d bytes not received, want 0", exp_q.size()); end
  endtask

  task automatic test_glitch;
    int d0, f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    ifc.rx = 1'b0;
    idle(4 * DIV);
    ifc.rx = 1'b1;
    idle(600);
    @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", ifc.busy); end
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL glitch_rx_done: got %0d want %0d", done_cnt, d0); end
    checks++;
    if (ferr_cnt !== f0) begin errors++; $display("FAIL glitch_frame_err: got %0d want %0d", ferr_cnt, f0); end
    checks++;
    if (ifc.data !== last_good) begin errors++; $display("FAIL glitch_data: got %h want %h", ifc.data, last_good); end
    idle(1);
  endtask

  task automatic test_frame_err;
    int d0, f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'h24, BIT_CLKS, 1'b0);
    idle(300);
    @(negedge clk);
    checks++;
    if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt - f0); end
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL ferr_rx_done: got %0d want %0d", done_cnt, d0); end
    checks++;
    if (ifc.data !== last_good) begin errors++; $display("FAIL ferr_data: got %h want %h", ifc.data, last_good); end
    idle(1);
  endtask

  task automatic test_reset_mid;
    int d0, f0;
    logic [7:0] e;
    d0 = done_cnt;
    f0 = ferr_cnt;
    ifc.rx = 1'b0; idle(BIT_CLKS);
    ifc.rx = 1'b1; idle(BIT_CLKS);
    ifc.rx = 1'b0; idle(BIT_CLKS);
    ifc.rx = 1'b1; idle(BIT_CLKS);
    ifc.rx = 1'b0; idle(200);
    rst = 1'b1;
    ifc.rx = 1'b1;
    idle(3);
    @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", ifc.busy); end
    checks++;
    if (ifc.data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", ifc.data); end
    idle(1);
    rst = 1'b0;
    last_good = 8'h00;
    idle(1000);
    checks++;
    if (done_cnt !== d0 || ferr_cnt !== f0) begin
      errors++;
      $display("FAIL rstmid_strobe: got done %0d ferr %0d want %0d %0d", done_cnt, ferr_cnt, d0, f0);
    end
    exp_q.push_back(uart_pkg::CMD_DOLLAR);
    send_frame(8'h24, BIT_CLKS, 1'b1);
    wait_done(d0 + 1, 200);
    while (rd_idx < got_q.size() && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q[rd_idx] !== e) begin errors++; $display("FAIL rstmid_data_after: got %h want %h", got_q[rd_idx], e); end
      rd_idx++;
      last_good = e;
    end
  endtask

  task automatic test_skew;
    int d0, f0;
    logic [7:0] e;
    d0 = done_cnt;
    f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, (BIT_CLKS * 102) / 100, 1'b1);
    idle(50);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, (BIT_CLKS * 98) / 100, 1'b1);
    wait_done(d0 + 2, 200);
    while (rd_idx < got_q.size() && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q[rd_idx] !== e) begin errors++; $display("FAIL skew_data: got %h want %h", got_q[rd_idx], e); end
      rd_idx++;
      last_good = e;
    end
    checks++;
    if (ferr_cnt !== f0) begin errors++; $display("FAIL skew_frame_err: got %0d want %0d", ferr_cnt, f0); end
  endtask

  task automatic test_invariants;
    checks++;
    if (both_cnt !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d want 0", both_cnt); end
    checks++;
    if (unstable_cnt !== 0) begin errors++; $display("FAIL data_stability: got %0d changes want 0", unstable_cnt); end
    checks++;
    if (rd_idx !== got_q.size()) begin errors++; $display("FAIL extra_bytes: got %0d want %0d", got_q.size(), rd_idx); end
  endtask

  initial begin
    ifc.rx = 1'b1;
    rst = 1'b1;
    idle(5);
    test_reset;
    rst = 1'b0;
    idle(20);
    test_single;
    idle(50);
    test_back_to_back;
    idle(50);
    test_glitch;
    test_frame_err;
    test_reset_mid;
    idle(50);
    test_skew;
    idle(20);
    test_invariants;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
